// File: rtl/sd_pkg.sv
// Shared definitions for the SD-card SPI slave and its command decoder.
package sd_pkg;

    // Direction of the slave's data/response phase, seen from the slave.
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int unsigned CMD_IDX_W = 6;
    localparam int unsigned CMD_ARG_W = 32;
    localparam int unsigned CRC7_W    = 7;
    localparam int unsigned CRC_BITS  = 40;
    localparam int unsigned BITCNT_W  = 6;

    localparam logic [CMD_IDX_W-1:0] CMD0  = 6'd0;
    localparam logic [CMD_IDX_W-1:0] CMD8  = 6'd8;
    localparam logic [CMD_IDX_W-1:0] CMD17 = 6'd17;
    localparam logic [CMD_IDX_W-1:0] CMD24 = 6'd24;
    localparam logic [CMD_IDX_W-1:0] CMD41 = 6'd41;
    localparam logic [CMD_IDX_W-1:0] CMD55 = 6'd55;
    localparam logic [CMD_IDX_W-1:0] CMD58 = 6'd58;

    // Response lengths in bytes (R1 alone, R7/R3 = R1 + 4 bytes).
    localparam int unsigned R1_LEN = 1;
    localparam int unsigned R7_LEN = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CRC,
        ST_CHECK,
        ST_WAIT_GO,
        ST_START,
        ST_XFER
    } dec_state_t;

    typedef struct packed {
        logic crc_err;
        logic frame_err;
        logic illegal_cmd;
    } cmd_flags_t;

    // Commands the card emulation understands.
    function automatic logic is_legal_cmd(input logic [CMD_IDX_W-1:0] idx);
        case (idx)
            CMD0, CMD8, CMD17, CMD24, CMD41, CMD55, CMD58: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), MSB-first, zero initial value.
module crc7_serial
    import sd_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic              i_bit_in,
    output logic [CRC7_W-1:0] o_crc
);

    logic [CRC7_W-1:0] r_crc;
    logic              w_fb;

    assign w_fb  = i_bit_in ^ r_crc[CRC7_W-1];
    assign o_crc = r_crc;

    // LFSR update: shift left, fold feedback into taps x^3 and x^0.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_crc <= '0;
        end else if (i_en) begin
            r_crc <= {r_crc[CRC7_W-2:0], 1'b0} ^ (w_fb ? 7'h09 : 7'h00);
        end
    end

endmodule

// File: rtl/sd_cmd_decoder.sv
// Decodes a 6-byte SPI SD command frame, checks framing/CRC7, publishes it,
// then runs the op/size/start handshake and tracks the phase until done.
// Frame byte k sits at i_cmd[8*k +: 8]; byte 0 is the first byte received.
module sd_cmd_decoder
    import sd_pkg::*;
#(
    parameter int unsigned COMMAND_SIZE         = 6,
    parameter int unsigned MEMORY_SIZE_IN_BYTES = 64,
    parameter int unsigned BLOCK_LEN            = 64,
    parameter int unsigned CRC_EN               = 1
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic [8*COMMAND_SIZE-1:0]               i_cmd,
    input  logic                                    i_transfer,
    input  logic                                    i_done,
    input  logic                                    i_go,
    output logic                                    o_op,
    output logic [$clog2(MEMORY_SIZE_IN_BYTES)-1:0] o_size,
    output logic                                    o_start,
    output logic [5:0]                              o_cmd_index,
    output logic [31:0]                             o_cmd_arg,
    output logic                                    o_cmd_valid,
    output logic                                    o_crc_err,
    output logic                                    o_frame_err,
    output logic                                    o_illegal_cmd,
    output logic                                    o_overrun,
    output logic                                    o_busy
);

    localparam int unsigned AW       = $clog2(MEMORY_SIZE_IN_BYTES);
    localparam int unsigned FRAME_W  = 8 * COMMAND_SIZE;
    localparam logic [AW-1:0] SZ_BLOCK = AW'(BLOCK_LEN - 1);
    localparam logic [AW-1:0] SZ_R7    = AW'(R7_LEN - 1);
    localparam logic [AW-1:0] SZ_R1    = AW'(R1_LEN - 1);
    localparam logic [BITCNT_W-1:0] BITCNT_INIT = BITCNT_W'(CRC_BITS - 1);

    dec_state_t              r_state;
    dec_state_t              w_next;
    logic [FRAME_W-1:0]      r_frame;
    logic [BITCNT_W-1:0]     r_bitcnt;
    logic [CRC7_W-1:0]       w_crc;
    logic [CRC_BITS-1:0]     w_crc_data;
    logic                    w_bit_in;
    logic                    w_load;
    logic                    w_crc_en;
    logic                    w_check;
    cmd_flags_t              w_flags;
    logic                    w_any_err;
    logic                    w_op;
    logic [AW-1:0]           w_size;
    logic [CMD_IDX_W-1:0]    w_index;
    logic [CMD_ARG_W-1:0]    w_arg;

    logic                    r_op;
    logic [AW-1:0]           r_size;
    logic                    r_start;
    logic [CMD_IDX_W-1:0]    r_cmd_index;
    logic [CMD_ARG_W-1:0]    r_cmd_arg;
    logic                    r_cmd_valid;
    logic                    r_crc_err;
    logic                    r_frame_err;
    logic                    r_illegal_cmd;
    logic                    r_overrun;
    logic                    r_busy;

    // Bytes 0..4 in wire order; the bit counter walks this MSB first.
    assign w_crc_data = {r_frame[7:0], r_frame[15:8], r_frame[23:16],
                         r_frame[31:24], r_frame[39:32]};
    assign w_bit_in   = w_crc_data[r_bitcnt];
    assign w_index    = r_frame[5:0];
    assign w_arg      = {r_frame[15:8], r_frame[23:16], r_frame[31:24], r_frame[39:32]};

    crc7_serial u_crc (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (w_load),
        .i_en     (w_crc_en),
        .i_bit_in (w_bit_in),
        .o_crc    (w_crc)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state and per-state control strobes.
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_crc_en = 1'b0;
        w_check  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_transfer) begin
                    w_load = 1'b1;
                    w_next = ST_CRC;
                end
            end
            ST_CRC: begin
                w_crc_en = 1'b1;
                if (r_bitcnt == '0) w_next = ST_CHECK;
            end
            ST_CHECK: begin
                w_check = 1'b1;
                w_next  = ST_WAIT_GO;
            end
            ST_WAIT_GO: begin
                if (i_go) w_next = ST_START;
            end
            ST_START: begin
                w_next = ST_XFER;
            end
            ST_XFER: begin
                if (i_done) w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Frame capture and CRC bit counter; the slave's cmd is not read again.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame  <= '0;
            r_bitcnt <= '0;
        end else if (w_load) begin
            r_frame  <= i_cmd;
            r_bitcnt <= BITCNT_INIT;
        end else if (w_crc_en && (r_bitcnt != '0)) begin
            r_bitcnt <= r_bitcnt - BITCNT_W'(1);
        end
    end

    // Error flags from the captured frame and the finished CRC.
    always_comb begin
        w_flags             = '0;
        w_flags.frame_err   = (r_frame[7:6] != 2'b01) || !r_frame[40];
        w_flags.crc_err     = (CRC_EN != 0) && (w_crc != r_frame[47:41]);
        w_flags.illegal_cmd = !is_legal_cmd(w_index);
    end

    assign w_any_err = |w_flags;

    // Phase direction and length; errors collapse to a bare R1.
    always_comb begin
        w_op   = OP_WRITE;
        w_size = SZ_R1;
        if (w_any_err) begin
            w_op   = OP_WRITE;
            w_size = SZ_R1;
        end else if (w_index == CMD17) begin
            w_op   = OP_WRITE;
            w_size = SZ_BLOCK;
        end else if (w_index == CMD24) begin
            w_op   = OP_READ;
            w_size = SZ_BLOCK;
        end else if ((w_index == CMD8) || (w_index == CMD58)) begin
            w_op   = OP_WRITE;
            w_size = SZ_R7;
        end
    end

    // Registered outputs; decoded fields hold from one CHECK to the next.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op          <= OP_WRITE;
            r_size        <= '0;
            r_start       <= 1'b0;
            r_cmd_index   <= '0;
            r_cmd_arg     <= '0;
            r_cmd_valid   <= 1'b0;
            r_crc_err     <= 1'b0;
            r_frame_err   <= 1'b0;
            r_illegal_cmd <= 1'b0;
            r_overrun     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_cmd_valid   <= w_check;
            r_crc_err     <= w_check && w_flags.crc_err;
            r_frame_err   <= w_check && w_flags.frame_err;
            r_illegal_cmd <= w_check && w_flags.illegal_cmd;
            r_start       <= (r_state == ST_START);
            r_overrun     <= i_transfer && (r_state != ST_IDLE);
            r_busy        <= (w_next != ST_IDLE);
            if (w_check) begin
                r_op        <= w_op;
                r_size      <= w_size;
                r_cmd_index <= w_index;
                r_cmd_arg   <= w_arg;
            end
        end
    end

    assign o_op          = r_op;
    assign o_size        = r_size;
    assign o_start       = r_start;
    assign o_cmd_index   = r_cmd_index;
    assign o_cmd_arg     = r_cmd_arg;
    assign o_cmd_valid   = r_cmd_valid;
    assign o_crc_err     = r_crc_err;
    assign o_frame_err   = r_frame_err;
    assign o_illegal_cmd = r_illegal_cmd;
    assign o_overrun     = r_overrun;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_sd_cmd_decoder.sv
// Scoreboard bench: one decoder with CRC checking, one without, same stimulus.
module tb_sd_cmd_decoder;

    localparam int unsigned AW = 6;

    typedef struct {
        int unsigned   cyc;
        logic [5:0]    idx;
        logic [31:0]   arg;
        logic          crc_e;
        logic          frm_e;
        logic          ill_e;
        logic          op;
        logic [AW-1:0] size;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [47:0]   cmd = '0;
    logic          transfer = 1'b0;
    logic          done = 1'b0;
    logic          go = 1'b0;

    logic          op_o   [2];
    logic [AW-1:0] size_o [2];
    logic          start_o[2];
    logic [5:0]    idx_o  [2];
    logic [31:0]   arg_o  [2];
    logic          vld_o  [2];
    logic          crc_o  [2];
    logic          frm_o  [2];
    logic          ill_o  [2];
    logic          ovr_o  [2];
    logic          busy_o [2];

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_errs = 0;
    exp_t sbq0[$];
    exp_t sbq1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sd_cmd_decoder #(.COMMAND_SIZE(6), .MEMORY_SIZE_IN_BYTES(64), .BLOCK_LEN(64), .CRC_EN(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_cmd(cmd), .i_transfer(transfer), .i_done(done), .i_go(go),
        .o_op(op_o[0]), .o_size(size_o[0]), .o_start(start_o[0]), .o_cmd_index(idx_o[0]),
        .o_cmd_arg(arg_o[0]), .o_cmd_valid(vld_o[0]), .o_crc_err(crc_o[0]), .o_frame_err(frm_o[0]),
        .o_illegal_cmd(ill_o[0]), .o_overrun(ovr_o[0]), .o_busy(busy_o[0]));

    sd_cmd_decoder #(.COMMAND_SIZE(6), .MEMORY_SIZE_IN_BYTES(64), .BLOCK_LEN(64), .CRC_EN(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_cmd(cmd), .i_transfer(transfer), .i_done(done), .i_go(go),
        .o_op(op_o[1]), .o_size(size_o[1]), .o_start(start_o[1]), .o_cmd_index(idx_o[1]),
        .o_cmd_arg(arg_o[1]), .o_cmd_valid(vld_o[1]), .o_crc_err(crc_o[1]), .o_frame_err(frm_o[1]),
        .o_illegal_cmd(ill_o[1]), .o_overrun(ovr_o[1]), .o_busy(busy_o[1]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c = '0;
        logic fb;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'b000_1001;
        end
        return c;
    endfunction

    function automatic logic [47:0] mk(input logic [7:0] b0, b1, b2, b3, b4, b5);
        return {b5, b4, b3, b2, b1, b0};
    endfunction

    function automatic exp_t model(input logic [47:0] f, input bit crc_en, input int unsigned c);
        exp_t e;
        logic [7:0] b [6];
        for (int k = 0; k < 6; k++) b[k] = f[8*k +: 8];
        e.cyc   = c;
        e.idx   = b[0][5:0];
        e.arg   = {b[1], b[2], b[3], b[4]};
        e.frm_e = (b[0][7:6] != 2'b01) || (b[5][0] == 1'b0);
        e.crc_e = crc_en && (crc7({b[0], b[1], b[2], b[3], b[4]}) != b[5][7:1]);
        e.ill_e = !(e.idx inside {6'd0, 6'd8, 6'd17, 6'd24, 6'd41, 6'd55, 6'd58});
        if (e.crc_e || e.frm_e || e.ill_e) begin e.op = 1'b1; e.size = 6'd0; end
        else if (e.idx == 6'd17)           begin e.op = 1'b1; e.size = 6'd63; end
        else if (e.idx == 6'd24)           begin e.op = 1'b0; e.size = 6'd63; end
        else if (e.idx == 6'd8 || e.idx == 6'd58) begin e.op = 1'b1; e.size = 6'd4; end
        else                               begin e.op = 1'b1; e.size = 6'd0; end
        return e;
    endfunction

    task automatic cmp_fields(input int k, input exp_t e);
        check($sformatf("d%0d_valid_cycle", k), 64'(cyc), 64'(e.cyc));
        check($sformatf("d%0d_index", k), 64'(idx_o[k]), 64'(e.idx));
        check($sformatf("d%0d_arg", k), 64'(arg_o[k]), 64'(e.arg));
        check($sformatf("d%0d_crc_err", k), 64'(crc_o[k]), 64'(e.crc_e));
        check($sformatf("d%0d_frame_err", k), 64'(frm_o[k]), 64'(e.frm_e));
        check($sformatf("d%0d_illegal", k), 64'(ill_o[k]), 64'(e.ill_e));
        check($sformatf("d%0d_op", k), 64'(op_o[k]), 64'(e.op));
        check($sformatf("d%0d_size", k), 64'(size_o[k]), 64'(e.size));
    endtask

    // Pop the oldest expectation whenever a decoder publishes a command.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (vld_o[0]) begin
                if (sbq0.size() == 0) check("d0_unexpected_valid", 64'(1), 64'(0));
                else begin e = sbq0.pop_front(); cmp_fields(0, e); end
            end
            if (vld_o[1]) begin
                if (sbq1.size() == 0) check("d1_unexpected_valid", 64'(1), 64'(0));
                else begin e = sbq1.pop_front(); cmp_fields(1, e); end
            end
            for (int k = 0; k < 2; k++)
                if (!vld_o[k] && (crc_o[k] || frm_o[k] || ill_o[k]))
                    check($sformatf("d%0d_flag_without_valid", k), 64'(1), 64'(0));
        end
    end

    task automatic wait_to(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_both(input string tag, input int sel, input logic [63:0] exp);
        for (int k = 0; k < 2; k++) begin
            case (sel)
                0: check($sformatf("d%0d_%s", k, tag), 64'(busy_o[k]), exp);
                1: check($sformatf("d%0d_%s", k, tag), 64'(start_o[k]), exp);
                2: check($sformatf("d%0d_%s", k, tag), 64'(ovr_o[k]), exp);
                default: check($sformatf("d%0d_%s", k, tag), 64'(vld_o[k]), exp);
            endcase
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("d%0d_%s_op", k, tag), 64'(op_o[k]), 64'(1));
            check($sformatf("d%0d_%s_size", k, tag), 64'(size_o[k]), 64'(0));
            check($sformatf("d%0d_%s_index", k, tag), 64'(idx_o[k]), 64'(0));
            check($sformatf("d%0d_%s_arg", k, tag), 64'(arg_o[k]), 64'(0));
            check($sformatf("d%0d_%s_busy", k, tag), 64'(busy_o[k]), 64'(0));
            check($sformatf("d%0d_%s_start", k, tag), 64'(start_o[k]), 64'(0));
            check($sformatf("d%0d_%s_valid", k, tag), 64'(vld_o[k]), 64'(0));
            check($sformatf("d%0d_%s_errs", k, tag),
                  64'({crc_o[k], frm_o[k], ill_o[k], ovr_o[k]}), 64'(0));
        end
    endtask

    // mode 0: plain; 1: overrun in XFER then done; 2: transfer together with done.
    task automatic run_cmd(input logic [47:0] f, input int mode);
        int unsigned t0;
        exp_t e0, e1;
        t0 = cyc;
        e0 = model(f, 1'b0, t0 + 42);
        e1 = model(f, 1'b1, t0 + 42);
        sbq0.push_back(e0);
        sbq1.push_back(e1);
        cmd = f;
        transfer = 1'b1;
        @(negedge clk);
        transfer = 1'b0;
        cmd = ~f;
        check_both("busy_cycle1", 0, 64'(1));
        wait_to(t0 + 20);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_to(t0 + 22);
        check_both("start_go_in_crc", 1, 64'(0));
        wait_to(t0 + 43);
        check("sb0_drained", 64'(sbq0.size()), 64'(0));
        check("sb1_drained", 64'(sbq1.size()), 64'(0));
        wait_to(t0 + 45);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check_both("busy_done_in_wait", 0, 64'(1));
        wait_to(t0 + 50);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check_both("start_n1", 1, 64'(0));
        @(negedge clk);
        check_both("start_n2", 1, 64'(1));
        @(negedge clk);
        check_both("start_n3", 1, 64'(0));
        check_both("busy_xfer", 0, 64'(1));
        if (mode == 1) begin
            cmd = mk(8'h51, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
            transfer = 1'b1;
            @(negedge clk);
            transfer = 1'b0;
            check_both("overrun_pulse", 2, 64'(1));
            check("d0_op_hold", 64'(op_o[0]), 64'(e0.op));
            check("d0_size_hold", 64'(size_o[0]), 64'(e0.size));
            check("d1_op_hold", 64'(op_o[1]), 64'(e1.op));
            check("d1_size_hold", 64'(size_o[1]), 64'(e1.size));
            @(negedge clk);
            check_both("overrun_end", 2, 64'(0));
            check_both("busy_after_overrun", 0, 64'(1));
        end
        done = 1'b1;
        if (mode == 2) transfer = 1'b1;
        @(negedge clk);
        done = 1'b0;
        transfer = 1'b0;
        check_both("busy_after_done", 0, 64'(0));
        if (mode == 2) begin
            check_both("overrun_with_done", 2, 64'(1));
            repeat (3) @(negedge clk);
            check_both("busy_frame_dropped", 0, 64'(0));
        end
    endtask

    initial begin
        logic [7:0] rb [6];
        logic [5:0] legal [7];
        int unsigned t0;
        legal = '{6'd0, 6'd8, 6'd17, 6'd24, 6'd41, 6'd55, 6'd58};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("after_reset");

        run_cmd(mk(8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95), 0);
        run_cmd(mk(8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87), 0);
        run_cmd(mk(8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h97), 0);
        run_cmd(mk(8'h51, 8'h00, 8'h00, 8'h12, 8'h34, 8'h01), 0);
        run_cmd(mk(8'h58, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01), 1);
        run_cmd(mk(8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 2);
        run_cmd(mk(8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95), 0);

        for (int i = 0; i < 4; i++) begin
            rb[0] = {2'b01, legal[$urandom_range(0, 6)]};
            for (int k = 1; k < 5; k++) rb[k] = 8'($urandom);
            rb[5] = (i % 2 == 0) ? {crc7({rb[0], rb[1], rb[2], rb[3], rb[4]}), 1'b1}
                                 : (8'($urandom) | 8'h01);
            run_cmd(mk(rb[0], rb[1], rb[2], rb[3], rb[4], rb[5]), 0);
        end

        // Reset while waiting for go: no start may follow.
        t0 = cyc;
        sbq0.push_back(model(mk(8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87), 1'b0, t0 + 42));
        sbq1.push_back(model(mk(8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87), 1'b1, t0 + 42));
        cmd = mk(8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87);
        transfer = 1'b1;
        @(negedge clk);
        transfer = 1'b0;
        wait_to(t0 + 45);
        check_both("busy_wait_go", 0, 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("rst_in_wait_go");
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_both("no_start_after_rst", 1, 64'(0));
        end
        check_both("busy_after_rst_go", 0, 64'(0));

        check("sb0_empty_end", 64'(sbq0.size()), 64'(0));
        check("sb1_empty_end", 64'(sbq1.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
